// File: rtl/ring_slot_tracker.sv
// ring_slot_tracker: owner of a circular slot ring. Slots are allocated at
// tail, marked complete in any order, and retired in order from head. A
// registered occupancy mask of the live region [head, tail) is published
// alongside registered count/full/empty.
// Optional feature: define RING_SLOT_TRACKER_ERR_EN to add a sticky err output
// flagging illegal done marks and alloc requests refused while a retire frees
// a slot in the same cycle.
module ring_slot_tracker #(
   parameter  int LOG_WIDTH = 32'sd6,
   localparam int WIDTH     = 32'sd1 << LOG_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_req,
   output logic                 alloc_gnt,
   output logic [LOG_WIDTH-1:0] alloc_idx,
   input  logic                 done_valid,
   input  logic [LOG_WIDTH-1:0] done_idx,
   output logic                 retire_valid,
   input  logic                 retire_ready,
   output logic [LOG_WIDTH-1:0] retire_idx,
   output logic [0:WIDTH-1]     occ_mask,
   output logic [LOG_WIDTH:0]   count,
   output logic                 full,
`ifdef RING_SLOT_TRACKER_ERR_EN
   output logic                 err,
`endif
   output logic                 empty
);

   localparam logic [LOG_WIDTH-1:0] IDX_ONE  = {{(LOG_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [LOG_WIDTH:0]   CNT_ZERO = {(LOG_WIDTH+1){1'b0}};
   localparam logic [LOG_WIDTH:0]   CNT_FULL = {1'b1, {LOG_WIDTH{1'b0}}};

   logic [LOG_WIDTH-1:0] head_r;
   logic [LOG_WIDTH-1:0] tail_r;
   logic [WIDTH-1:0]     done_r;

   logic [LOG_WIDTH-1:0] head_s;
   logic [LOG_WIDTH-1:0] tail_s;
   logic [LOG_WIDTH:0]   count_s;
   logic [WIDTH-1:0]     done_s;
   logic [0:WIDTH-1]     occ_s;
   logic                 retire_fire_s;
   logic                 done_legal_s;

   // Slot idx is live when its circular distance from hd is below cnt; this
   // covers the wrapped case and resolves head==tail through cnt alone.
   function automatic logic in_region(input logic [LOG_WIDTH-1:0] idx,
                                      input logic [LOG_WIDTH-1:0] hd,
                                      input logic [LOG_WIDTH:0]   cnt);
      logic [LOG_WIDTH-1:0] off;
      off = idx - hd;
      return ({1'b0, off} < cnt);
   endfunction

   assign alloc_idx  = tail_r;
   assign retire_idx = head_r;

   // Handshakes, done-mark legality and next-state head/tail/count/done/mask.
   always_comb begin
      alloc_gnt     = alloc_req & ~full;
      retire_valid  = ~empty & done_r[head_r];
      retire_fire_s = retire_valid & retire_ready;
      done_legal_s  = done_valid & in_region(done_idx, head_r, count) & ~done_r[done_idx];
      head_s        = head_r;
      tail_s        = tail_r;
      done_s        = done_r;
      occ_s         = '0;

      // A legal mark never targets head while head is retiring (it must be
      // not-done), and never targets tail on a grant (tail is outside region).
      if (done_legal_s) begin
         done_s[done_idx] = 1'b1;
      end else begin
         done_s = done_s;
      end

      if (retire_fire_s) begin
         done_s[head_r] = 1'b0;
         head_s         = head_r + IDX_ONE;
      end else begin
         head_s = head_r;
      end

      if (alloc_gnt) begin
         done_s[tail_r] = 1'b0;
         tail_s         = tail_r + IDX_ONE;
      end else begin
         tail_s = tail_r;
      end

      count_s = count + {{LOG_WIDTH{1'b0}}, alloc_gnt} - {{LOG_WIDTH{1'b0}}, retire_fire_s};

      for (int i = 32'sd0; i < WIDTH; i++) begin
         occ_s[i] = in_region(LOG_WIDTH'(i), head_s, count_s);
      end
   end

   // Ring state and published occupancy, all cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r   <= '0;
         tail_r   <= '0;
         done_r   <= '0;
         count    <= CNT_ZERO;
         occ_mask <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         head_r   <= head_s;
         tail_r   <= tail_s;
         done_r   <= done_s;
         count    <= count_s;
         occ_mask <= occ_s;
         full     <= (count_s == CNT_FULL);
         empty    <= (count_s == CNT_ZERO);
      end
   end

`ifdef RING_SLOT_TRACKER_ERR_EN
   logic err_set_s;

   // Error sources: any rejected done mark, or an alloc refused by full while
   // a retire is freeing a slot in the same cycle (no full bypass).
   always_comb begin
      err_set_s = (done_valid & ~done_legal_s) | (alloc_req & full & retire_fire_s);
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else begin
         err <= err | err_set_s;
      end
   end
`endif

endmodule

// File: tb/tb_ring_slot_tracker.sv
// tb_ring_slot_tracker: directed scenarios plus randomized traffic for an
// 8-slot ring_slot_tracker, checked against a queue-based reference model of
// the live region (oldest entry first, each with its completion flag).
module tb_ring_slot_tracker;

   localparam int LW = 3;
   localparam int W  = 8;

   logic          clk;
   logic          rst;
   logic          alloc_req;
   logic          alloc_gnt;
   logic [LW-1:0] alloc_idx;
   logic          done_valid;
   logic [LW-1:0] done_idx;
   logic          retire_valid;
   logic          retire_ready;
   logic [LW-1:0] retire_idx;
   logic [0:W-1]  occ_mask;
   logic [LW:0]   count;
   logic          full;
   logic          empty;
`ifdef RING_SLOT_TRACKER_ERR_EN
   logic          err;
`endif

   ring_slot_tracker #(.LOG_WIDTH(LW)) dut (
      .clk          (clk),
      .rst          (rst),
      .alloc_req    (alloc_req),
      .alloc_gnt    (alloc_gnt),
      .alloc_idx    (alloc_idx),
      .done_valid   (done_valid),
      .done_idx     (done_idx),
      .retire_valid (retire_valid),
      .retire_ready (retire_ready),
      .retire_idx   (retire_idx),
      .occ_mask     (occ_mask),
      .count        (count),
      .full         (full),
`ifdef RING_SLOT_TRACKER_ERR_EN
      .err          (err),
`endif
      .empty        (empty)
   );

   typedef struct {
      int idx;
      bit dn;
   } ent_t;

   ent_t q[$];
   int   m_tail;
   bit   m_err;
   int   n_cmp;
   int   n_bad;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int m_head();
      return (q.size() > 0) ? q[0].idx : m_tail;
   endfunction

   // Compare every registered output against the model (called at negedge).
   task automatic check_regs();
      logic [0:W-1] em;
      em = '0;
      for (int j = 0; j < q.size(); j++) em[q[j].idx] = 1'b1;
      chk("count", 32'(count), 32'(q.size()));
      chk("full", 32'(full), 32'(q.size() == W));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("occ_mask", 32'(occ_mask), 32'(em));
      chk("alloc_idx", 32'(alloc_idx), 32'(m_tail));
      chk("retire_idx", 32'(retire_idx), 32'(m_head()));
`ifdef RING_SLOT_TRACKER_ERR_EN
      chk("err", 32'(err), 32'(m_err));
`endif
   endtask

   // One clock cycle: drive at negedge, check handshakes, update model at
   // posedge, check registered outputs at the following negedge.
   task automatic step(input bit r, input bit req, input bit dv, input int di, input bit rr);
      bit m_full, e_gnt, e_rv, fire;
      int k;
      rst          = r;
      alloc_req    = req;
      done_valid   = dv;
      done_idx     = LW'(di);
      retire_ready = rr;
      #1;
      m_full = (q.size() == W);
      e_gnt  = req && !m_full;
      e_rv   = (q.size() > 0) && q[0].dn;
      if (!r) begin
         chk("alloc_gnt", 32'(alloc_gnt), 32'(e_gnt));
         chk("retire_valid", 32'(retire_valid), 32'(e_rv));
      end
      @(posedge clk);
      if (r) begin
         q.delete();
         m_tail = 0;
         m_err  = 1'b0;
      end else begin
         fire = e_rv && rr;
         k = -1;
         if (dv) begin
            for (int j = 0; j < q.size(); j++) begin
               if (q[j].idx == di && !q[j].dn) k = j;
            end
         end
         if (k >= 0) q[k].dn = 1'b1;
         else if (dv) m_err = 1'b1;
         if (req && m_full && fire) m_err = 1'b1;
         if (fire) void'(q.pop_front());
         if (e_gnt) begin
            q.push_back('{m_tail, 1'b0});
            m_tail = (m_tail + 1) % W;
         end
      end
      @(negedge clk);
      check_regs();
   endtask

   initial begin
      int di, pct;
      n_cmp = 0;
      n_bad = 0;
      m_tail = 0;
      m_err = 1'b0;
      rst = 1'b1;
      alloc_req = 1'b0;
      done_valid = 1'b0;
      done_idx = '0;
      retire_ready = 1'b0;
      @(negedge clk);

      // Reset then idle.
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_mask", 32'(occ_mask), 32'h00);

      // Three grants, out-of-order completion, in-order retire.
      repeat (3) step(0, 1, 0, 0, 1);
      chk("p2_mask3", 32'(occ_mask), 32'(8'b11100000));
      step(0, 0, 1, 2, 1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 1, 1);
      chk("p2_mask_a", 32'(occ_mask), 32'(8'b01100000));
      step(0, 0, 0, 0, 1);
      chk("p2_mask_b", 32'(occ_mask), 32'(8'b00100000));
      step(0, 0, 0, 0, 1);
      chk("p2_mask_c", 32'(occ_mask), 32'(8'b00000000));

      // Fill, refuse a 9th, no full bypass on a same-cycle retire.
      step(1, 0, 0, 0, 0);
      repeat (8) step(0, 1, 0, 0, 0);
      chk("p3_full", 32'(full), 32'd1);
      chk("p3_mask", 32'(occ_mask), 32'(8'b11111111));
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 1);
      chk("p3_count7", 32'(count), 32'd7);
      step(0, 1, 0, 0, 0);
      chk("p3_tail_wrap", 32'(alloc_idx), 32'd1);

      // Wrap: head=6, count=4, then illegal marks, then alloc+retire.
      step(1, 0, 0, 0, 0);
      repeat (6) step(0, 1, 0, 0, 0);
      for (int j = 0; j < 6; j++) step(0, 0, 1, j, 0);
      repeat (6) step(0, 0, 0, 0, 1);
      repeat (4) step(0, 1, 0, 0, 0);
      chk("p4_mask", 32'(occ_mask), 32'(8'b11000011));
      step(0, 0, 1, 6, 0);
      step(0, 0, 1, 6, 0);
      step(0, 0, 1, 5, 0);
      step(0, 1, 0, 0, 1);
      chk("p4_count", 32'(count), 32'd4);
      chk("p4_mask2", 32'(occ_mask), 32'(8'b11100001));

      // Reset mid-operation with count=5 and alloc_req high.
      step(0, 1, 0, 0, 0);
      chk("p6_count5", 32'(count), 32'd5);
      step(1, 1, 0, 0, 1);
      chk("p6_count", 32'(count), 32'd0);
      chk("p6_mask", 32'(occ_mask), 32'h00);

      // Randomized traffic with alternating fill/drain bias.
      for (int i = 0; i < 3000; i++) begin
         pct = ((i / 150) % 2 == 1) ? 85 : 30;
         if (q.size() > 0 && $urandom_range(0, 3) != 0)
            di = q[$urandom_range(0, q.size() - 1)].idx;
         else
            di = int'($urandom_range(0, W - 1));
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 99) < pct),
              ($urandom_range(0, 1) == 1),
              di,
              ($urandom_range(0, 99) < 70));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ring_slot_tracker.md
Name: ring_slot_tracker

Overview:
- Sequential owner of a circular slot ring: allocates slots at tail, accepts out-of-order completion marks, retires completed slots in order from head.
- Publishes a registered occupancy mask of the live region [head, tail) for the prefetcher's slot arrays.
- Performs the index-to-mask mapping internally; no combinational mask generator is needed downstream.
- Sits between the prefetch request issuer (allocate), the memory response path (done) and the consumer (retire).

Parameters:
- LOG_WIDTH, 6, index width in bits.
- WIDTH, 1<<LOG_WIDTH, number of ring slots; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_req  in  1  allocation request.
- alloc_gnt  out  1  allocation granted this cycle.
- alloc_idx  out  LOG_WIDTH  slot index granted; equals tail.
- done_valid  in  1  completion mark strobe.
- done_idx  in  LOG_WIDTH  slot being marked complete.
- retire_valid  out  1  head slot is occupied and complete.
- retire_ready  in  1  consumer accepts retire.
- retire_idx  out  LOG_WIDTH  equals head.
- occ_mask  out  [0:WIDTH-1]  registered occupancy; bit i = slot i, element 0 leftmost.
- count  out  LOG_WIDTH+1  occupied slot count, 0..WIDTH.
- full  out  1  count == WIDTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst high at a clk edge): head=0, tail=0, count=0, done bitmap=0, occ_mask all 0. Outputs follow: empty=1, full=0, alloc_gnt=0, retire_valid=0, alloc_idx=0, retire_idx=0. Reset wins over every other input in the same cycle, and reset mid-operation discards all state.
- alloc_gnt = alloc_req & ~full (combinational). On grant, tail increments mod WIDTH (natural wrap at LOG_WIDTH bits) and done[tail] clears.
- No full bypass: when full, a same-cycle retire does not enable a same-cycle allocation.
- retire_valid = ~empty & done[head] (combinational). A retire occurs when retire_valid & retire_ready: done[head] clears, head increments mod WIDTH.
- At most one allocation and one retire per cycle.
- count next = count + grant - retire. A simultaneous grant and retire leaves count unchanged.
- A done mark is legal only if done_idx lies in the occupied region at cycle start and done[done_idx]=0; a legal mark sets done[done_idx].
- Illegal done marks are ignored and state is unchanged. These are: an unoccupied slot, a slot being granted in the same cycle, or an already-done slot.
- A done mark on the head slot takes effect next cycle: retire_valid rises one cycle after the mark.
- Region membership uses circular compare against head and count:
  - count==WIDTH: all slots are members.
  - count==0: no slots are members.
  - head==tail is disambiguated by count only.
- occ_mask is registered, updated every cycle from the next-state head and count. It reflects post-update state one cycle after the causing edge:
  - bits head..tail-1 are set, wrapping through WIDTH-1 to 0;
  - all ones when full;
  - all zeros when empty.
- count, full and empty are registered and consistent with occ_mask in the same cycle.

Optional Feature:
- Macro RING_SLOT_TRACKER_ERR_EN.
- Defined: adds output err (1 bit), reset 0. err is sticky-set on any illegal done mark, and on alloc_req while full only if the same cycle also has a retire.
- Defined: err clears only on rst. Legal behaviour is otherwise identical.
- Undefined: no err port; illegal marks are silently ignored.

Test Plan (LOG_WIDTH=3, WIDTH=8):
- Reset then idle → empty=1, count=0, occ_mask=00000000, retire_valid=0, alloc_idx=0.
- 3 grants, then done on 2,0,1 in separate cycles, retire_ready=1 → retire_valid rises only after done[0]; retire_idx sequence 0,1,2; occ_mask goes 11100000 → 01100000 → 00100000 → 00000000.
- Fill 8 slots → full=1, occ_mask=11111111, alloc_gnt=0 on a 9th request. Mark done[0] and retire while alloc_req=1 in the same cycle → no grant that cycle; count=7; grant on the next cycle with alloc_idx=0.
- Wrap: head=6, count=4 → occ_mask=11000011. One alloc plus one retire in the same cycle → count stays 4 and occ_mask=11100001.
- Illegal done on slot 5 (unoccupied), then a duplicate done on slot 6 → no state change; err=1 when RING_SLOT_TRACKER_ERR_EN is defined.
- rst asserted with count=5 and alloc_req=1 → next cycle all reset values hold and no grant is issued.
